ahb_decoder: RTL and testbench
==============================

// Module: ahb_decoder
// PURPOSE
//  Address-phase decoder and data-phase select register feeding the 4:1 AHB slave response mux.
//  Decodes haddr into hsel_1..hsel_3 for three mapped slaves. Routes every unmapped address to an
//  internal default slave, which drives mux input 4.
//  Registers the decoded index on each accepted address phase. The result is output as sel[1:0]
//  for the mux during the data phase.
// PARAMETERS
//  S1_BASE  32'h0000_0000  slave 1 region base
//  S1_MASK  32'hF000_0000  slave 1 compare mask
//  S2_BASE  32'h1000_0000  slave 2 region base
//  S2_MASK  32'hF000_0000  slave 2 compare mask
//  S3_BASE  32'h2000_0000  slave 3 region base
//  S3_MASK  32'hF000_0000  slave 3 compare mask
// PORTS
//  hclk         in   1   bus clock; all state on rising edge
//  hreset       in   1   synchronous, active-high reset
//  haddr        in   32  address-phase address
//  htrans       in   2   transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hready       in   1   global HREADY (mux hreadyout output)
//  hsel_1       out  1   slave 1 select (combinational, address phase)
//  hsel_2       out  1   slave 2 select
//  hsel_3       out  1   slave 3 select
//  sel          out  2   registered data-phase index to mux: 00/01/10 = slaves 1-3, 11 = default slave
//  hrdata_4     out  32  default slave read data, constant 32'h0
//  hreadyout_4  out  1   default slave ready
//  hresp_4      out  1   default slave response: 0 OKAY, 1 ERROR
// BEHAVIOUR
//  Decode (combinational):
//   - hit_n = ((haddr & Sn_MASK) == Sn_BASE).
//   - Priority order is S1 > S2 > S3. Overlapping regions select only the highest-priority hit.
//   - Exactly one of hsel_1..3 is high, or none.
//   - hsel_n does not depend on htrans or hready.
//   - No hit gives next_idx = 2'b11 (default slave); otherwise next_idx = n-1.
//  Select register:
//   - Reset: sel = 2'b11.
//   - hready = 1 at a clock edge: sel <= next_idx, for every htrans value including IDLE.
//   - hready = 0 at a clock edge: sel holds. Wait states stretch the data phase.
//   - Latency: exactly one clock from address phase to data phase.
//  Default slave FSM (states DS_OK, DS_ERR1, DS_ERR2):
//   - Reset: DS_OK, with hreadyout_4 = 1 and hresp_4 = 0.
//   - Trigger: hready = 1 and next_idx == 11 and htrans[1] == 1.
//   - DS_OK: trigger moves to DS_ERR1; otherwise stays in DS_OK. IDLE/BUSY to unmapped addresses get a
//     zero-wait OKAY.
//   - DS_ERR1: hreadyout_4 = 0, hresp_4 = 1. Always moves to DS_ERR2.
//   - DS_ERR2: hreadyout_4 = 1, hresp_4 = 1.
//     - Trigger present: back-to-back error, go to DS_ERR1.
//     - No trigger: go to DS_OK.
//   - In DS_OK the outputs are hreadyout_4 = 1 and hresp_4 = 0.
//   - hrdata_4 = 0 in all states.
//  Boundary cases:
//   - Mapped transfer accepted during DS_ERR2: go to DS_OK, and sel moves to the mapped index.
//   - Only while sel == 11 does hready reflect the default slave. DS_ERR1 therefore freezes sel, and
//     no new trigger is possible.
//   - haddr = 32'hFFFF_FFFF with default parameters is unmapped and selects the default slave.
//   - hreset asserted in any state:
//     - At the next edge: DS_OK and sel = 11.
//     - Any in-flight error is abandoned.
//     - Reset has priority over the trigger in the same cycle.
// STRUCTURE
//  Shared package ahb_pkg:
//   - HTRANS_IDLE / BUSY / NONSEQ / SEQ localparams.
//   - HRESP_OKAY / ERROR.
//   - Default-slave state encodings.
//   - Default memory-map constants.
//  One sub-module: ahb_default_slave. It holds the FSM and drives hrdata_4, hreadyout_4 and hresp_4.
//  The decode logic and the sel register stay in the top module.
// TESTING
//  1. Reset: hold hreset for 2 clocks -> sel = 11, hreadyout_4 = 1, hresp_4 = 0, all hsel_n = 0
//     when haddr = 32'h3000_0000.
//  2. Mapped decode: haddr = 32'h1000_0040, NONSEQ, hready = 1 -> hsel_2 = 1 in the same cycle;
//     sel = 01 after 1 clock; hreadyout_4 and hresp_4 stay 1 and 0.
//  3. Wait-state hold: sel = 01. Drive hready = 0 for 3 clocks while haddr changes to
//     32'h2000_0000 -> sel stays 01. After hready = 1, sel = 10.
//  4. Unmapped NONSEQ: haddr = 32'h8000_0000, hready = 1 -> the next cycle has sel = 11,
//     hreadyout_4 = 0, hresp_4 = 1. The cycle after has hreadyout_4 = 1, hresp_4 = 1. Then OKAY.
//  5. Back-to-back: unmapped SEQ presented during DS_ERR2 -> DS_ERR1 again. Then present
//     IDLE to 32'h8000_0000 in DS_ERR2 -> DS_OK with zero-wait OKAY.
//  6. Reset during DS_ERR1 -> next edge gives hreadyout_4 = 1, hresp_4 = 0, sel = 11.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB constants, default memory map and default-slave state encoding.
// Pure declarations; no logic, no latency.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] MAP_S1_BASE = 32'h0000_0000;
    localparam logic [31:0] MAP_S1_MASK = 32'hF000_0000;
    localparam logic [31:0] MAP_S2_BASE = 32'h1000_0000;
    localparam logic [31:0] MAP_S2_MASK = 32'hF000_0000;
    localparam logic [31:0] MAP_S3_BASE = 32'h2000_0000;
    localparam logic [31:0] MAP_S3_MASK = 32'hF000_0000;

    localparam logic [1:0] SEL_S1      = 2'b00;
    localparam logic [1:0] SEL_S2      = 2'b01;
    localparam logic [1:0] SEL_S3      = 2'b10;
    localparam logic [1:0] SEL_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for active transfers, zero-wait OKAY otherwise.
// Response follows the triggering address phase by one clock; hreadyout_4 low in the first error cycle.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic        hclk,
    input  logic        hreset,
    input  logic        trigger,
    output logic [31:0] hrdata_4,
    output logic        hreadyout_4,
    output logic        hresp_4
);

    ds_state_e state_q;
    ds_state_e state_d;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= DS_OK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hreadyout_4 = 1'b1;
        hresp_4     = HRESP_OKAY;
        hrdata_4    = 32'h0;
        case (state_q)
            DS_OK: begin
                if (trigger) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                hreadyout_4 = 1'b0;
                hresp_4     = HRESP_ERROR;
                state_d     = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_4 = HRESP_ERROR;
                state_d = trigger ? DS_ERR1 : DS_OK;
            end
            default: begin
                state_d = DS_OK;
            end
        endcase
    end

endmodule

// File: rtl/ahb_decoder.sv
// AHB address decoder with priority S1 > S2 > S3 and a data-phase mux select register.
// hsel_n combinational; sel lags the address phase by one clock and holds while hready is low.
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter logic [31:0] S1_BASE = MAP_S1_BASE,
    parameter logic [31:0] S1_MASK = MAP_S1_MASK,
    parameter logic [31:0] S2_BASE = MAP_S2_BASE,
    parameter logic [31:0] S2_MASK = MAP_S2_MASK,
    parameter logic [31:0] S3_BASE = MAP_S3_BASE,
    parameter logic [31:0] S3_MASK = MAP_S3_MASK
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hready,
    output logic        hsel_1,
    output logic        hsel_2,
    output logic        hsel_3,
    output logic [1:0]  sel,
    output logic [31:0] hrdata_4,
    output logic        hreadyout_4,
    output logic        hresp_4
);

    logic       hit_1;
    logic       hit_2;
    logic       hit_3;
    logic [1:0] next_idx;
    logic       xfer_active;
    logic       ds_trigger;
    logic [1:0] sel_q;
    logic [1:0] sel_d;

    always_comb begin
        hit_1    = region_hit(haddr, S1_BASE, S1_MASK);
        hit_2    = region_hit(haddr, S2_BASE, S2_MASK);
        hit_3    = region_hit(haddr, S3_BASE, S3_MASK);
        hsel_1   = hit_1;
        hsel_2   = hit_2 & ~hit_1;
        hsel_3   = hit_3 & ~hit_1 & ~hit_2;
        next_idx = SEL_DEFAULT;
        if (hit_1) begin
            next_idx = SEL_S1;
        end else if (hit_2) begin
            next_idx = SEL_S2;
        end else if (hit_3) begin
            next_idx = SEL_S3;
        end
    end

    // IDLE and BUSY never reach the error path; they get a zero-wait OKAY.
    always_comb begin
        xfer_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
        ds_trigger  = hready && (next_idx == SEL_DEFAULT) && xfer_active;
    end

    always_comb begin
        sel_d = sel_q;
        if (hready) begin
            sel_d = next_idx;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            sel_q <= SEL_DEFAULT;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel = sel_q;

    ahb_default_slave u_default_slave (
        .hclk        (hclk),
        .hreset      (hreset),
        .trigger     (ds_trigger),
        .hrdata_4    (hrdata_4),
        .hreadyout_4 (hreadyout_4),
        .hresp_4     (hresp_4)
    );

endmodule

// File: tb/tb_ahb_decoder.sv
// Directed and random stimulus for ahb_decoder, checked against a memory-map reference model.
module tb_ahb_decoder;

    logic        hclk;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hsel_1;
    logic        hsel_2;
    logic        hsel_3;
    logic [1:0]  sel;
    logic [31:0] hrdata_4;
    logic        hreadyout_4;
    logic        hresp_4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory map and behavioural state: selected slave number and
    // how many cycles into an error response the default slave is (0 = none).
    logic [31:0] m_base [3] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
    logic [31:0] m_mask [3] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
    int m_sel = 3;
    int m_err = 0;

    ahb_decoder dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .haddr       (haddr),
        .htrans      (htrans),
        .hready      (hready),
        .hsel_1      (hsel_1),
        .hsel_2      (hsel_2),
        .hsel_3      (hsel_3),
        .sel         (sel),
        .hrdata_4    (hrdata_4),
        .hreadyout_4 (hreadyout_4),
        .hresp_4     (hresp_4)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 3; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one address phase, check the decode, clock it, then check registered outputs.
    task automatic step(input logic rst, input logic [31:0] a, input logic [1:0] t, input logic r);
        int  idx;
        bit  trig;
        hreset = rst;
        haddr  = a;
        htrans = t;
        hready = r;
        #1;
        idx = ref_decode(a);
        chk("hsel_1", {31'b0, hsel_1}, {31'b0, idx == 0});
        chk("hsel_2", {31'b0, hsel_2}, {31'b0, idx == 1});
        chk("hsel_3", {31'b0, hsel_3}, {31'b0, idx == 2});
        trig = r && (idx == 3) && t[1];
        if (rst) begin
            m_sel = 3;
            m_err = 0;
        end else begin
            if (m_err == 1) m_err = 2;
            else            m_err = trig ? 1 : 0;
            if (r) m_sel = idx;
        end
        @(posedge hclk);
        #1;
        chk("sel", {30'b0, sel}, m_sel);
        chk("hreadyout_4", {31'b0, hreadyout_4}, {31'b0, m_err != 1});
        chk("hresp_4", {31'b0, hresp_4}, {31'b0, m_err != 0});
        chk("hrdata_4", hrdata_4, 32'h0);
    endtask

    initial begin
        logic [31:0] r32;
        logic [3:0]  nib;
        logic [31:0] a;

        // Reset held for two clocks with an unmapped address present
        step(1'b1, 32'h3000_0000, 2'b00, 1'b1);
        step(1'b1, 32'h3000_0000, 2'b00, 1'b1);
        chk("t1_sel", {30'b0, sel}, 32'h3);
        chk("t1_rdy", {31'b0, hreadyout_4}, 32'h1);
        chk("t1_resp", {31'b0, hresp_4}, 32'h0);

        // Mapped decode to slave 2
        step(1'b0, 32'h1000_0040, 2'b10, 1'b1);
        chk("t2_sel", {30'b0, sel}, 32'h1);

        // Wait states hold sel while the address moves to slave 3
        step(1'b0, 32'h2000_0000, 2'b10, 1'b0);
        step(1'b0, 32'h2000_0000, 2'b10, 1'b0);
        step(1'b0, 32'h2000_0000, 2'b10, 1'b0);
        chk("t3_hold", {30'b0, sel}, 32'h1);
        step(1'b0, 32'h2000_0000, 2'b10, 1'b1);
        chk("t3_sel", {30'b0, sel}, 32'h2);

        // Unmapped NONSEQ: two-cycle error, then OKAY
        step(1'b0, 32'h8000_0000, 2'b10, 1'b1);
        chk("t4_err1_rdy", {31'b0, hreadyout_4}, 32'h0);
        chk("t4_err1_resp", {31'b0, hresp_4}, 32'h1);
        step(1'b0, 32'h8000_0000, 2'b00, 1'b0);
        chk("t4_err2_rdy", {31'b0, hreadyout_4}, 32'h1);
        chk("t4_err2_resp", {31'b0, hresp_4}, 32'h1);
        step(1'b0, 32'h0000_0000, 2'b00, 1'b1);
        chk("t4_ok_resp", {31'b0, hresp_4}, 32'h0);

        // Back-to-back error, then IDLE to an unmapped address in ERR2
        step(1'b0, 32'h8000_0000, 2'b10, 1'b1);
        step(1'b0, 32'h8000_0000, 2'b10, 1'b0);
        step(1'b0, 32'h8000_0004, 2'b11, 1'b1);
        chk("t5_b2b_rdy", {31'b0, hreadyout_4}, 32'h0);
        step(1'b0, 32'h8000_0004, 2'b11, 1'b0);
        step(1'b0, 32'h8000_0000, 2'b00, 1'b1);
        chk("t5_idle_rdy", {31'b0, hreadyout_4}, 32'h1);
        chk("t5_idle_resp", {31'b0, hresp_4}, 32'h0);

        // Mapped transfer accepted during ERR2
        step(1'b0, 32'h9000_0000, 2'b10, 1'b1);
        step(1'b0, 32'h9000_0000, 2'b10, 1'b0);
        step(1'b0, 32'h0000_1000, 2'b10, 1'b1);
        chk("b_err2_map_sel", {30'b0, sel}, 32'h0);
        chk("b_err2_map_resp", {31'b0, hresp_4}, 32'h0);

        // All-ones address is unmapped; then reset during ERR1 beats a trigger
        step(1'b0, 32'hFFFF_FFFF, 2'b10, 1'b1);
        chk("b_ffff_sel", {30'b0, sel}, 32'h3);
        step(1'b1, 32'h8000_0000, 2'b10, 1'b1);
        chk("t6_rdy", {31'b0, hreadyout_4}, 32'h1);
        chk("t6_resp", {31'b0, hresp_4}, 32'h0);
        chk("t6_sel", {30'b0, sel}, 32'h3);

        for (int i = 0; i < 400; i++) begin
            r32 = $urandom();
            nib = 4'($urandom_range(0, 15));
            a   = {nib, r32[27:0]};
            if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFF;
            step($urandom_range(0, 39) == 0, a, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
